// File: rtl/wb_if.sv
// Wishbone B4 pipelined bus bundle (32-bit address and data).
// The master modport drives the request side; the slave modport drives the response side.
interface wb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_m;
  logic [31:0] dat_s;
  logic        ack;
  logic        err;
  logic        stall;

  modport master (
    output cyc, stb, we, sel, adr, dat_m,
    input  dat_s, ack, err, stall
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_m,
    output dat_s, ack, err, stall
  );
endinterface

// File: rtl/wb_arbiter2.sv
// Two-master to one-slave Wishbone B4 pipelined arbiter. The bus is owned for a whole cyc span.
// Outstanding requests are counted so that responses only reach the master that issued them.
module wb_arbiter2 #(
  parameter int MaxOutstanding = 4,
  parameter bit RoundRobin     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  wb_if.slave  m0,
  wb_if.slave  m1,
  wb_if.master s
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam logic [3:0] MaxCnt = 4'(MaxOutstanding);

  state_t     state, state_n;
  logic       last, last_n;   // 0 = m0 held the last grant, 1 = m1
  logic [3:0] cnt, cnt_n;
  logic       own0, own1;
  logic       full, accept, resp, abort;

  function automatic state_t pick(input logic c0, input logic c1, input logic lst);
    state_t nx;
    if (c0 && c1) begin
      if (RoundRobin) nx = lst ? GRANT0 : GRANT1;
      else            nx = GRANT0;
    end else if (c0) begin
      nx = GRANT0;
    end else if (c1) begin
      nx = GRANT1;
    end else begin
      nx = IDLE;
    end
    return nx;
  endfunction

  assign own0 = (state == GRANT0);
  assign own1 = (state == GRANT1);
  assign full = (cnt == MaxCnt);

  // Responses with nothing outstanding (spurious, or after an abort) are swallowed.
  assign resp   = (s.ack | s.err) & (cnt != 4'd0) & (state != IDLE);
  assign accept = ((own0 & m0.cyc & m0.stb) | (own1 & m1.cyc & m1.stb)) & ~full & ~s.stall;
  assign abort  = (own0 & ~m0.cyc) | (own1 & ~m1.cyc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      last  <= last_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    last_n  = last;
    unique case (state)
      IDLE:    state_n = pick(m0.cyc, m1.cyc, last);
      GRANT0:  if (!m0.cyc) state_n = pick(1'b0, m1.cyc, last);
      GRANT1:  if (!m1.cyc) state_n = pick(m0.cyc, 1'b0, last);
      default: state_n = IDLE;
    endcase
    if (state_n == GRANT0 && state != GRANT0) last_n = 1'b0;
    if (state_n == GRANT1 && state != GRANT1) last_n = 1'b1;
  end

  // A dropped cyc abandons whatever is still in flight.
  always_comb begin
    cnt_n = cnt;
    if (abort)                cnt_n = 4'd0;
    else if (accept && !resp) cnt_n = cnt + 4'd1;
    else if (resp && !accept) cnt_n = cnt - 4'd1;
  end

  always_comb begin
    s.cyc    = 1'b0;
    s.stb    = 1'b0;
    s.we     = 1'b0;
    s.sel    = 4'd0;
    s.adr    = 32'd0;
    s.dat_m  = 32'd0;
    m0.stall = 1'b1;
    m0.ack   = 1'b0;
    m0.err   = 1'b0;
    m1.stall = 1'b1;
    m1.ack   = 1'b0;
    m1.err   = 1'b0;
    m0.dat_s = s.dat_s;
    m1.dat_s = s.dat_s;
    if (own0) begin
      s.cyc    = m0.cyc;
      s.stb    = m0.stb & ~full;
      s.we     = m0.we;
      s.sel    = m0.sel;
      s.adr    = m0.adr;
      s.dat_m  = m0.dat_m;
      m0.stall = s.stall | full;
      m0.ack   = s.ack & resp;
      m0.err   = s.err & resp;
    end else if (own1) begin
      s.cyc    = m1.cyc;
      s.stb    = m1.stb & ~full;
      s.we     = m1.we;
      s.sel    = m1.sel;
      s.adr    = m1.adr;
      s.dat_m  = m1.dat_m;
      m1.stall = s.stall | full;
      m1.ack   = s.ack & resp;
      m1.err   = s.err & resp;
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: a round-robin and a fixed-priority instance run on identical stimulus,
// each compared every cycle against an ownership / outstanding-tag-list reference model.
module tb_wb_arbiter2;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        mc[2], ms[2], mw[2];
  logic [3:0]  msel[2];
  logic [31:0] madr[2], mdat[2];
  logic        ss_stall, ss_ack, ss_err;
  logic [31:0] ss_dat;

  logic        o_ack[4], o_err[4], o_stall[4];
  logic [31:0] o_dat[4];
  logic        o_scyc[2], o_sstb[2], o_swe[2];
  logic [3:0]  o_ssel[2];
  logic [31:0] o_sadr[2], o_sdat[2];
  logic [3:0]  cnt_obs[2];

  wb_if mi[4] ();
  wb_if si[2] ();

  for (genvar g = 0; g < 4; g++) begin : g_m
    assign mi[g].cyc   = mc[g % 2];
    assign mi[g].stb   = ms[g % 2];
    assign mi[g].we    = mw[g % 2];
    assign mi[g].sel   = msel[g % 2];
    assign mi[g].adr   = madr[g % 2];
    assign mi[g].dat_m = mdat[g % 2];
    assign o_ack[g]    = mi[g].ack;
    assign o_err[g]    = mi[g].err;
    assign o_stall[g]  = mi[g].stall;
    assign o_dat[g]    = mi[g].dat_s;
  end

  for (genvar g = 0; g < 2; g++) begin : g_s
    assign si[g].stall = ss_stall;
    assign si[g].ack   = ss_ack;
    assign si[g].err   = ss_err;
    assign si[g].dat_s = ss_dat;
    assign o_scyc[g]   = si[g].cyc;
    assign o_sstb[g]   = si[g].stb;
    assign o_swe[g]    = si[g].we;
    assign o_ssel[g]   = si[g].sel;
    assign o_sadr[g]   = si[g].adr;
    assign o_sdat[g]   = si[g].dat_m;
  end

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wb_arbiter2 #(
      .MaxOutstanding(MAXO),
      .RoundRobin    ((g == 0) ? 1'b1 : 1'b0)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .m0 (mi[2*g]),
      .m1 (mi[2*g+1]),
      .s  (si[g])
    );
    assign cnt_obs[g] = u_dut.cnt;
  end

  int total = 0;
  int bad   = 0;
  int issued;

  // Reference model: owner (-1 none), last granted master, ordered list of issuing-master tags.
  int own[2], lst[2], n[2];
  int tag[2][16];
  bit rr[2] = '{1'b1, 1'b0};

  task automatic chk_eq(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, obs, exp);
    end
  endtask

  function automatic int pick(int d);
    int nx;
    if (mc[0] && mc[1]) nx = rr[d] ? 1 - lst[d] : 0;
    else if (mc[0])     nx = 0;
    else if (mc[1])     nx = 1;
    else                nx = -1;
    if (nx >= 0) lst[d] = nx;
    return nx;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      own[d] = -1;
      lst[d] = 1;
      n[d]   = 0;
    end
  endtask

  task automatic model_edge(int d);
    int o;
    bit full, resp, acc;
    if (rst) begin
      own[d] = -1; lst[d] = 1; n[d] = 0;
      return;
    end
    o    = own[d];
    full = (n[d] == MAXO);
    resp = (ss_ack || ss_err) && (n[d] > 0);
    acc  = 1'b0;
    if (o >= 0) acc = mc[o] && ms[o] && !full && !ss_stall;
    if (o >= 0 && !mc[o]) begin
      n[d]   = 0;
      own[d] = pick(d);
    end else begin
      if (resp) begin
        for (int i = 0; i < 15; i++) tag[d][i] = tag[d][i+1];
        n[d]--;
      end
      if (acc) begin
        tag[d][n[d]] = o;
        n[d]++;
      end
      if (o < 0) own[d] = pick(d);
    end
  endtask

  task automatic check_dut(int d);
    int o, rt, idx;
    bit full, resp, e_cyc, e_stb;
    o     = own[d];
    full  = (n[d] == MAXO);
    resp  = (ss_ack || ss_err) && (n[d] > 0);
    rt    = resp ? tag[d][0] : -1;
    e_cyc = 1'b0;
    e_stb = 1'b0;
    if (o >= 0) begin
      e_cyc = mc[o];
      e_stb = ms[o] && !full;
    end
    chk_eq($sformatf("d%0d_s_cyc", d), 64'(o_scyc[d]), 64'(e_cyc));
    chk_eq($sformatf("d%0d_s_stb", d), 64'(o_sstb[d]), 64'(e_stb));
    if (o >= 0) begin
      chk_eq($sformatf("d%0d_s_adr", d), 64'(o_sadr[d]), 64'(madr[o]));
      chk_eq($sformatf("d%0d_s_dat", d), 64'(o_sdat[d]), 64'(mdat[o]));
      chk_eq($sformatf("d%0d_s_we", d),  64'(o_swe[d]),  64'(mw[o]));
      chk_eq($sformatf("d%0d_s_sel", d), 64'(o_ssel[d]), 64'(msel[o]));
    end
    for (int k = 0; k < 2; k++) begin
      idx = 2 * d + k;
      chk_eq($sformatf("d%0d_m%0d_stall", d, k), 64'(o_stall[idx]),
             (o == k) ? 64'(ss_stall || full) : 64'd1);
      chk_eq($sformatf("d%0d_m%0d_ack", d, k), 64'(o_ack[idx]), 64'((rt == k) && ss_ack));
      chk_eq($sformatf("d%0d_m%0d_err", d, k), 64'(o_err[idx]), 64'((rt == k) && ss_err));
      chk_eq($sformatf("d%0d_m%0d_dat", d, k), 64'(o_dat[idx]), 64'(ss_dat));
    end
    chk_eq($sformatf("d%0d_cnt", d), 64'(cnt_obs[d]), 64'(n[d]));
  endtask

  // Called at a negedge with inputs set; returns at the following negedge.
  task automatic tick();
    #1;
    for (int d = 0; d < 2; d++) check_dut(d);
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_edge(d);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      mc[k] = 1'b0; ms[k] = 1'b0; mw[k] = 1'b0;
      msel[k] = 4'hF; madr[k] = 32'd0; mdat[k] = 32'd0;
    end
    ss_stall = 1'b0; ss_ack = 1'b0; ss_err = 1'b0; ss_dat = 32'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    tick();

    // m0 alone: single write, acked one cycle after acceptance
    mc[0] = 1; ms[0] = 1; mw[0] = 1; madr[0] = 32'h1000; mdat[0] = 32'hDEADBEEF;
    tick();
    #1 chk_eq("t1_s_adr", 64'(o_sadr[0]), 64'h1000);
    chk_eq("t1_s_dat", 64'(o_sdat[0]), 64'hDEADBEEF);
    tick();
    ms[0] = 0; ss_ack = 1;
    #1 chk_eq("t1_m0_ack", 64'(o_ack[0]), 64'd1);
    chk_eq("t1_m1_ack", 64'(o_ack[1]), 64'd0);
    tick();
    ss_ack = 0; mc[0] = 0;
    tick();
    tick();

    // simultaneous requests: alternation vs fixed priority
    do_reset();
    mc[0] = 1; mc[1] = 1;
    tick();
    #1 chk_eq("t2_a_m0_owner", 64'(o_stall[0]), 64'd0);
    chk_eq("t2_a_m1_wait", 64'(o_stall[1]), 64'd1);
    chk_eq("t2_b_m0_owner", 64'(o_stall[2]), 64'd0);
    tick();
    mc[0] = 0;
    tick();
    #1 chk_eq("t2_a_m1_owner", 64'(o_stall[1]), 64'd0);
    chk_eq("t2_a_no_gap", 64'(o_scyc[0]), 64'd1);
    tick();
    mc[1] = 0; tick();
    mc[0] = 1; tick();
    tick();
    mc[0] = 0; tick();
    mc[0] = 1; mc[1] = 1;
    tick();
    #1 chk_eq("t2_a_rr_m1", 64'(o_stall[1]), 64'd0);
    chk_eq("t2_b_fixed_m0", 64'(o_stall[2]), 64'd0);
    chk_eq("t2_b_m1_wait", 64'(o_stall[3]), 64'd1);
    tick();
    mc[0] = 0; mc[1] = 0;
    tick();
    tick();

    // m1 six reads against a four-deep outstanding limit
    do_reset();
    mc[1] = 1; ms[1] = 1; mw[1] = 0; madr[1] = 32'h2000;
    tick();
    issued = 0;
    repeat (4) begin
      tick();
      issued++;
      madr[1] += 32'd4;
    end
    #1 chk_eq("t3_full_stall", 64'(o_stall[1]), 64'd1);
    chk_eq("t3_stb_gated", 64'(o_sstb[0]), 64'd0);
    tick();
    for (int k = 0; k < 6; k++) begin
      ms[1] = (issued < 6); ss_ack = 1; ss_dat = 32'h11 + 32'(k);
      #1 chk_eq($sformatf("t3_ack%0d", k), 64'(o_ack[1]), 64'd1);
      chk_eq($sformatf("t3_dat%0d", k), 64'(o_dat[1]), 64'h11 + 64'(k));
      if (ms[1] && !o_stall[1]) begin
        issued++;
        madr[1] += 32'd4;
      end
      tick();
    end
    ss_ack = 0; ms[1] = 0; mc[1] = 0;
    tick();
    chk_eq("t3_issued", 64'(issued), 64'd6);

    // abort with two outstanding, then a late ack
    mc[0] = 1; ms[0] = 1; mw[0] = 1; madr[0] = 32'h3000;
    tick();
    tick();
    tick();
    mc[0] = 0; ms[0] = 0; mc[1] = 1;
    #1 chk_eq("t4_scyc_drop", 64'(o_scyc[0]), 64'd0);
    tick();
    ss_ack = 1;
    #1 chk_eq("t4_late_m0", 64'(o_ack[0]), 64'd0);
    chk_eq("t4_late_m1", 64'(o_ack[1]), 64'd0);
    chk_eq("t4_m1_granted", 64'(o_stall[1]), 64'd0);
    chk_eq("t4_cnt", 64'(cnt_obs[0]), 64'd0);
    tick();
    ss_ack = 0;

    // error on the second of three writes, with a direct owner change first
    mc[1] = 0; mc[0] = 1; ms[0] = 1; mw[0] = 1; madr[0] = 32'h4000;
    tick();
    repeat (3) begin
      tick();
      madr[0] += 32'd4;
    end
    ms[0] = 0; ss_ack = 1;
    tick();
    ss_ack = 0; ss_err = 1;
    #1 chk_eq("t5_m0_err", 64'(o_err[0]), 64'd1);
    chk_eq("t5_m1_err", 64'(o_err[1]), 64'd0);
    chk_eq("t5_cnt_before", 64'(cnt_obs[0]), 64'd2);
    tick();
    ss_err = 0;
    #1 chk_eq("t5_cnt_after", 64'(cnt_obs[0]), 64'd1);
    ss_ack = 1;
    tick();
    ss_ack = 0; mc[0] = 0;
    tick();

    // reset mid-transfer with three outstanding
    mc[1] = 1; ms[1] = 1; mw[1] = 0;
    repeat (4) tick();
    ms[1] = 0;
    #1 chk_eq("t6_cnt3", 64'(cnt_obs[0]), 64'd3);
    rst = 1;
    tick();
    rst = 0; ss_ack = 1;
    #1 chk_eq("t6_scyc", 64'(o_scyc[0]), 64'd0);
    chk_eq("t6_m0_stall", 64'(o_stall[0]), 64'd1);
    chk_eq("t6_m1_stall", 64'(o_stall[1]), 64'd1);
    chk_eq("t6_m1_ack", 64'(o_ack[1]), 64'd0);
    chk_eq("t6_cnt0", 64'(cnt_obs[0]), 64'd0);
    tick();
    clear_inputs();
    tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(7) == 0) mc[k] = ~mc[k];
        ms[k]   = mc[k] & ($urandom_range(2) != 0);
        mw[k]   = 1'($urandom);
        msel[k] = 4'($urandom);
        madr[k] = $urandom;
        mdat[k] = $urandom;
      end
      ss_stall = ($urandom_range(3) == 0);
      ss_ack   = ($urandom_range(2) == 0);
      ss_err   = ($urandom_range(9) == 0);
      ss_dat   = $urandom;
      rst      = ($urandom_range(199) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
